clip_array: RTL and testbench

Parametrised, pipelined saturation stage for the FME datapath. It takes a packed vector of signed filter results, applies an optional round-half-up arithmetic right shift per beat, and clips each channel to unsigned OUT_WIDTH pixels. It is the generalised replacement for fixed-width per-lane clipping cells: channel count, input and output widths are parameters, and it adds a valid/ready handshake with backpressure and a saturation-event counter for quality monitoring. It sits between the interpolation filter array and the sub-pel candidate buffers.

---
 rtl/clip_array_if.sv | 27 ++
 rtl/clip_array.sv | 125 ++++++++++++
 tb/tb_clip_array.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clip_array_if.sv
// clip_array_if: handshake and data bundle of the clip_array saturation stage.
//   in_valid/in_ready/in_data/shift : upstream beat (filter results + shift amount)
//   out_valid/out_ready/out_data    : downstream beat (clipped unsigned pixels)
// master = surrounding datapath / bench, slave = clip_array.
interface clip_array_if #(
  parameter int CHANNELS  = 27,
  parameter int IN_WIDTH  = 11,
  parameter int OUT_WIDTH = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic [2:0]                      shift;
  logic [CHANNELS*IN_WIDTH-1:0]    in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [CHANNELS*OUT_WIDTH-1:0]   out_data;

  modport master (
    output in_valid, shift, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, shift, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/clip_array.sv
// clip_array: two-stage pipelined round/shift + unsigned clip for CHANNELS lanes.
//   clock      : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   enable     : global clock enable, 0 freezes everything except sat_clear
//   bus        : clip_array_if slave (in/out valid-ready streams, shift)
//   sat_clear  : synchronous clear of sat_count
//   sat_count  : number of clipped lanes since last clear, sticky at max
module clip_array #(
  parameter int CHANNELS  = 27,
  parameter int IN_WIDTH  = 11,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_MAX = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  clip_array_if.slave          bus,
  input  logic                 sat_clear,
  output logic [CNT_WIDTH-1:0] sat_count
);

  // One extra bit so the rounding add can never overflow.
  localparam int YW    = IN_WIDTH + 1;
  localparam int PC_W  = $clog2(CHANNELS + 1);
  localparam int SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

  logic                                s1_valid;
  logic [CHANNELS-1:0][YW-1:0]         s1_y;
  logic                                s2_valid;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0]  s2_data;

  logic                                s1_load;
  logic                                s1_adv;
  logic                                s2_adv;

  logic [2:0]                          shift_eff;
  logic [YW-1:0]                       rnd;
  logic [CHANNELS-1:0][YW-1:0]         y_next;
  logic [CHANNELS-1:0][OUT_WIDTH-1:0]  clip_data;
  logic [CHANNELS-1:0]                 sat_flag;
  logic [PC_W-1:0]                     pop;
  logic [SUM_W-1:0]                    sum;
  logic [CNT_WIDTH-1:0]                sat_next;

  // Handshake: s2 drains on out_ready; s1 may move into s2 whenever s2 is
  // empty or draining, which is what keeps the pipe at one beat per cycle.
  assign s2_adv        = enable & s2_valid & bus.out_ready;
  assign s1_adv        = enable & s1_valid & (~s2_valid | bus.out_ready);
  assign bus.in_ready  = enable & (~s1_valid | ~s2_valid | bus.out_ready);
  assign s1_load       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;

  // Stage 1: clamp shift, round half up, arithmetic shift.
  always_comb begin
    shift_eff = (bus.shift > 3'(SHIFT_MAX)) ? 3'(SHIFT_MAX) : bus.shift;
    // 2^(s-1) for s > 0, zero for s = 0
    rnd       = (YW'(1) << shift_eff) >> 1;
    for (int k = 0; k < CHANNELS; k++) begin
      y_next[k] = YW'(($signed({bus.in_data[k*IN_WIDTH + IN_WIDTH-1],
                                bus.in_data[k*IN_WIDTH +: IN_WIDTH]})
                      + $signed(rnd)) >>> shift_eff);
    end
  end

  // Stage 2: clip to [0, 2^OUT_WIDTH-1] and flag lanes where a bound applied.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (s1_y[k][YW-1]) begin
        clip_data[k] = '0;
        sat_flag[k]  = 1'b1;
      end else if (s1_y[k][YW-2:OUT_WIDTH] != '0) begin
        clip_data[k] = '1;
        sat_flag[k]  = 1'b1;
      end else begin
        clip_data[k] = s1_y[k][OUT_WIDTH-1:0];
        sat_flag[k]  = 1'b0;
      end
    end
  end

  // Saturation counter: a coincident clear restarts from this beat's count.
  always_comb begin
    pop = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pop = pop + PC_W'(sat_flag[k]);
    end
    sum      = (sat_clear ? '0 : SUM_W'(sat_count)) + SUM_W'(pop);
    sat_next = (sum > SUM_W'({CNT_WIDTH{1'b1}})) ? {CNT_WIDTH{1'b1}}
                                                 : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      sat_count <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_y     <= y_next;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_data  <= clip_data;
      end else if (s2_adv) begin
        s2_valid <= 1'b0;
      end

      // sat_clear acts even while enable is low
      if (s1_adv) begin
        sat_count <= sat_next;
      end else if (sat_clear) begin
        sat_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clip_array.sv
// tb_clip_array: directed checks of clip_array with 6 lanes and a 4-bit
// saturation counter so the sticky maximum is reachable quickly.
module tb_clip_array;

  localparam int CH  = 6;
  localparam int IW  = 11;
  localparam int OW  = 8;
  localparam int CW  = 4;

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic          sat_clear;
  logic [CW-1:0] sat_count;

  int n_checks;
  int n_fail;
  int n_in;
  int n_out;
  logic acc;
  logic xfer;

  clip_array_if #(.CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  clip_array #(
    .CHANNELS (CH),
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .SHIFT_MAX(5),
    .CNT_WIDTH(CW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .bus      (bus),
    .sat_clear(sat_clear),
    .sat_count(sat_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [CH*IW-1:0] pin(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5);
    logic [CH*IW-1:0] v;
    int a [CH];
    a = '{a0, a1, a2, a3, a4, a5};
    for (int k = 0; k < CH; k++) v[k*IW +: IW] = a[k][IW-1:0];
    return v;
  endfunction

  function automatic logic [CH*OW-1:0] pout(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5);
    logic [CH*OW-1:0] v;
    int a [CH];
    a = '{a0, a1, a2, a3, a4, a5};
    for (int k = 0; k < CH; k++) v[k*OW +: OW] = a[k][OW-1:0];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sh, input logic [CH*IW-1:0] d);
    bus.in_valid = v;
    bus.shift    = sh;
    bus.in_data  = d;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    enable        = 1'b1;
    sat_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.shift     = 3'd0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_sat_count", 64'(sat_count),     64'd0);
    #9 reset_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // Shift 0, mixed clipping; 4 lanes saturate
    drive(1'b1, 3'd0, pin(-5, 300, 128, -1024, 1023, 0));
    step();
    drive(1'b0, 3'd0, '0);
    check("lat1_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("s0_out_valid", 64'(bus.out_valid), 64'd1);
    check("s0_out_data",  64'(bus.out_data),  64'(pout(0, 255, 128, 0, 255, 0)));
    check("s0_sat_count", 64'(sat_count),     64'd4);
    step();
    check("s0_drained", 64'(bus.out_valid), 64'd0);

    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clear_alone", 64'(sat_count), 64'd0);

    // Shift 5 then shift 7 (clamped to 5), back to back
    drive(1'b1, 3'd5, pin(1000, -16, 15, 1008, 1023, 0));
    step();
    drive(1'b1, 3'd7, pin(1000, -16, 15, 1008, 1023, 0));
    step();
    drive(1'b0, 3'd0, '0);
    check("s5_out_valid", 64'(bus.out_valid), 64'd1);
    check("s5_out_data",  64'(bus.out_data),  64'(pout(31, 0, 0, 32, 32, 0)));
    step();
    check("s7_out_valid", 64'(bus.out_valid), 64'd1);
    check("s7_out_data",  64'(bus.out_data),  64'(pout(31, 0, 0, 32, 32, 0)));
    check("s5_sat_count", 64'(sat_count),     64'd0);
    step();

    // Shift 1: 1023 -> 512 clipped, 509 -> 255 exact, -1 -> 0 exact, -2 -> -1 clipped
    drive(1'b1, 3'd1, pin(1023, 509, -1, -2, 3, 0));
    step();
    drive(1'b0, 3'd0, '0);
    step();
    check("s1_out_data",  64'(bus.out_data), 64'(pout(255, 255, 0, 0, 2, 0)));
    check("s1_sat_count", 64'(sat_count),    64'd2);
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;

    // 10-beat stream, out_ready low in cycles 3..5
    n_in  = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 40 && n_out < 10; cyc++) begin
      drive(n_in < 10, 3'd0, pin(n_in * 10, n_in, n_in + 1, n_in + 2, n_in + 3, 255 - n_in));
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      acc  = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (cyc >= 3 && cyc <= 5) begin
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_hold", 64'(bus.out_data),
              64'(pout(n_out * 10, n_out, n_out + 1, n_out + 2, n_out + 3, 255 - n_out)));
      end
      if (cyc == 6) check("release_in_ready", 64'(bus.in_ready), 64'd1);
      if (cyc >= 2) check("stream_no_gap", 64'(bus.out_valid), 64'd1);
      if (xfer) check("stream_data", 64'(bus.out_data),
                      64'(pout(n_out * 10, n_out, n_out + 1, n_out + 2, n_out + 3, 255 - n_out)));
      @(posedge clock);
      #1;
      if (acc)  n_in++;
      if (xfer) n_out++;
    end
    drive(1'b0, 3'd0, '0);
    bus.out_ready = 1'b1;
    check("stream_out_count", 64'(n_out), 64'd10);
    check("stream_in_count",  64'(n_in),  64'd10);
    step();

    // Sticky counter: 20 beats with one clipped lane each
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'd0, pin(300, i, 0, 0, 0, 0));
      step();
    end
    drive(1'b0, 3'd0, '0);
    step();
    step();
    check("sticky_max", 64'(sat_count), 64'd15);

    // Clear coincident with a beat carrying two clipped lanes
    drive(1'b1, 3'd0, pin(300, -1, 0, 0, 0, 0));
    step();
    drive(1'b0, 3'd0, '0);
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clear_incr", 64'(sat_count), 64'd2);
    check("clear_incr_data", 64'(bus.out_data), 64'(pout(255, 0, 0, 0, 0, 0)));
    step();

    // enable = 0 freezes the pipe but honours sat_clear
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, pin(10, 20, 30, 40, 50, 60));
    step();
    drive(1'b0, 3'd0, '0);
    step();
    check("en_pre_valid", 64'(bus.out_valid), 64'd1);
    enable        = 1'b0;
    sat_clear     = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, pin(1, 1, 1, 1, 1, 1));
    #1;
    check("en0_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("en0_hold_valid", 64'(bus.out_valid), 64'd1);
    check("en0_hold_data",  64'(bus.out_data),  64'(pout(10, 20, 30, 40, 50, 60)));
    check("en0_clear",      64'(sat_count),     64'd0);
    sat_clear = 1'b0;
    drive(1'b0, 3'd0, '0);
    enable    = 1'b1;
    step();
    check("en1_drain", 64'(bus.out_valid), 64'd0);
    step();
    check("en0_no_accept", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset with two beats in flight
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, pin(300, 0, 0, 0, 0, 0));
    step();
    drive(1'b1, 3'd0, pin(1, 2, 3, 4, 5, 6));
    step();
    drive(1'b0, 3'd0, '0);
    check("full_in_ready",  64'(bus.in_ready), 64'd0);
    check("pre_rst_sat",    64'(sat_count),    64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_sat",   64'(sat_count),     64'd0);
    check("async_rst_data",  64'(bus.out_data),  64'd0);
    #2 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_empty1", 64'(bus.out_valid), 64'd0);
    step();
    check("post_rst_empty2", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 3'd0, pin(7, 8, 9, 10, 11, 12));
    step();
    drive(1'b0, 3'd0, '0);
    check("post_rst_lat1", 64'(bus.out_valid), 64'd0);
    step();
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);
    check("post_rst_data",  64'(bus.out_data),  64'(pout(7, 8, 9, 10, 11, 12)));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
